alu_issue: RTL
==============

Name: alu_issue

Overview:
- Single-issue decode/issue/writeback stage that drives the RV32I integer ALU.
- Accepts 32-bit OP and OP-IMM instructions over a valid/ready handshake, then decodes them.
- Reads operands from an internal 32x32 register file and presents ra/rb/func3/func7 to the ALU.
- Captures the ALU result and writes it back, with a 3-stage pipeline: D (decode/read), EX (drive ALU), WB (write).

Parameters:
XLEN, 32, datapath width; only 32 supported
NREGS, 32, architectural registers; x0 hardwired zero

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  stage can accept this cycle
in_instr  in  32  RV32I instruction word
alu_ra  out  32  ALU operand A (rs1 value)
alu_rb  out  32  ALU operand B (rs2 value or sign-extended imm)
alu_func3  out  3  ALU function select
alu_func7  out  7  ALU function modifier
alu_rd  in  32  combinational ALU result for current EX operands
wb_valid  out  1  writeback occurring this cycle
wb_addr  out  5  destination register
wb_data  out  32  written value
illegal  out  1  one-cycle pulse: accepted word was not a legal OP/OP-IMM
dbg_raddr  in  5  debug read address
dbg_rdata  out  32  debug read data (combinational, includes WB bypass)

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset:
  - Clears all registers to 0 and clears the EX and WB valid bits.
  - in_ready=0 while rst=1. alu_* outputs=0, wb_valid=0, illegal=0.
- Handshake:
  - A transfer occurs on a rising edge with in_valid&&in_ready.
  - in_instr is sampled only on a transfer.
  - in_ready is not a function of in_valid.
- Latency:
  - Accepted at edge N: EX occupies cycle N+1, WB occupies cycle N+2.
  - The register file is updated at the end of cycle N+2.
  - Throughput is 1/cycle when there is no stall.
- Decode:
  - OP (0110011): legal func7 is 0000000 for all func3. 0100000 is legal only for func3 000 and 101.
  - OP-IMM (0010011): imm = sign-extended instr[31:20].
    - func3 001/101: func7 is forwarded as instr[31:25]. Legal: 001 needs 0000000; 101 needs 0000000 or 0100000.
    - All other func3: alu_func7 is forced to 0000000 (prevents ADDI being seen as SUB).
  - Shifts (func3 001/101, OP and OP-IMM): alu_rb is masked to rb[4:0], zero-extended.
- Illegal instructions:
  - Any other opcode/func7 is accepted as a bubble: no EX activity, no writeback.
  - illegal pulses in cycle N+1.
- Empty EX drives alu_* = 0.
- Register x0:
  - Reads return 0.
  - rd=x0 still goes through EX, but wb_valid is suppressed (wb_valid=0).
- WB bypass:
  - A D-stage read of a register being written in the same cycle returns wb_data.
  - Always present, independent of the optional feature.
- EX hazard: the D instruction reads rs1/rs2 (nonzero) equal to the rd of a valid EX instruction. Resolution per Optional Feature.
- Reset mid-operation discards EX and WB contents with no writeback.

Optional Feature:
ALU_ISSUE_FWD_EN
- Defined: an EX hazard forwards alu_rd combinationally into the D operand capture, so there is no stall.
- Undefined:
  - in_ready=0 for one cycle on an EX hazard.
  - The instruction is re-sampled next cycle and obtains the value via the WB bypass.
- Results are architecturally identical either way; only timing differs.

Decomposition:
- alu_issue_pkg:
  - Opcode constants OPC_OP, OPC_OP_IMM.
  - Func7 constants F7_BASE, F7_ALT.
  - Func3 constants F3_SLL, F3_SRL_SRA.
  - Typedef ex_stage_t {valid, rd, ra, rb, func3, func7}.
  - Typedef wb_stage_t {valid, addr, data}.
- Sub-module rv_regfile: 2 read ports plus debug read port, 1 write port, sync reset, x0 hardwired, write-first bypass.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 back-to-back -> x3=2. With FWD_EN: no in_ready drop. Without: one-cycle in_ready=0 on each dependent issue.
- ADDI x1,x0,0x400 (imm[11:5]=0100000) -> alu_func7=0000000, x1=0x400, not SUB.
- SRAI x5,x4,4 with x4=0x80000000 -> alu_func7=0100000, alu_func3=101, alu_rb=4. SLL x6,x4,x7 with x7=0x23 -> alu_rb=3.
- Word 0x0000006F (JAL) and OP with func7=0000001 -> illegal pulses cycle N+1 each; no wb_valid; register file unchanged.
- ADDI x0,x0,7 then ADD x1,x0,x0 -> no writeback for x0; x1=0; dbg_rdata(x0)=0.
- rst asserted while 2 instructions in flight -> no wb_valid after reset; dbg_rdata=0 for all registers; in_ready=1 first cycle after rst deasserts.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants and pipeline-stage types for the alu_issue decode/issue/writeback stage.
package alu_issue_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        logic [2:0]      func3;
        logic [6:0]      func7;
    } ex_stage_t;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_stage_t;

    function automatic logic is_shift(input logic [2:0] func3);
        return (func3 == F3_SLL) || (func3 == F3_SRL_SRA);
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32x32 integer register file: two operand read ports, one debug read port, one write port.
// x0 reads as zero; reads of the register being written this cycle return the write data.
module rv_regfile
    import alu_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    input  logic [AW-1:0]   dbg_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] dbg_data_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    // NOTE: the architecture requires every register to read 0 after reset, so this
    // array is reset explicitly; that rules out mapping it onto a reset-less RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == '0) ? '0 :
                        (we_i && (waddr_i == rs1_addr_i)) ? wdata_i : regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == '0) ? '0 :
                        (we_i && (waddr_i == rs2_addr_i)) ? wdata_i : regs_q[rs2_addr_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 :
                        (we_i && (waddr_i == dbg_addr_i)) ? wdata_i : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// D/EX/WB issue stage for an external combinational RV32I ALU (OP and OP-IMM only).
// Build option ALU_ISSUE_FWD_EN: forward the EX result into D instead of stalling one cycle.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_ra,
    output logic [31:0] alu_rb,
    output logic [2:0]  alu_func3,
    output logic [6:0]  alu_func7,
    input  logic [31:0] alu_rd,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    ex_stage_t ex_q, ex_d;
    wb_stage_t wb_q, wb_d;
    logic      illegal_q, illegal_d;

    logic [6:0]      opcode;
    logic [AW-1:0]   rd_addr, rs1_addr, rs2_addr;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;

    assign opcode   = in_instr[6:0];
    assign rd_addr  = in_instr[11:7];
    assign func3    = in_instr[14:12];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign func7    = in_instr[31:25];
    assign imm      = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    logic       dec_legal, dec_is_op, dec_shift;
    logic [6:0] dec_func7;

    assign dec_is_op = (opcode == OPC_OP);
    assign dec_shift = is_shift(func3);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        dec_legal = 1'b0;
        dec_func7 = F7_BASE;
        case (opcode)
            OPC_OP: begin
                dec_func7 = func7;
                dec_legal = (func7 == F7_BASE) ||
                            ((func7 == F7_ALT) && ((func3 == F3_ADD_SUB) || (func3 == F3_SRL_SRA)));
            end
            OPC_OP_IMM: begin
                // Non-shift immediates carry imm bits in [31:25]; keep them off func7 so ADDI never subtracts.
                if (dec_shift) begin
                    dec_func7 = func7;
                    dec_legal = (func7 == F7_BASE) || ((func7 == F7_ALT) && (func3 == F3_SRL_SRA));
                end else begin
                    dec_legal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] rs1_val, rs2_val;

    rv_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .dbg_addr_i (dbg_raddr),
        .rs1_data_o (rs1_val),
        .rs2_data_o (rs2_val),
        .dbg_data_o (dbg_rdata),
        .we_i       (wb_q.valid),
        .waddr_i    (wb_q.addr),
        .wdata_i    (wb_q.data)
    );

    logic rs1_hit, rs2_hit;
    assign rs1_hit = ex_q.valid && (rs1_addr != '0) && (rs1_addr == ex_q.rd);
    assign rs2_hit = ex_q.valid && dec_is_op && (rs2_addr != '0) && (rs2_addr == ex_q.rd);

    logic [XLEN-1:0] op_a, op_b_reg, op_b_raw, op_b;

`ifdef ALU_ISSUE_FWD_EN
    assign op_a     = rs1_hit ? alu_rd : rs1_val;
    assign op_b_reg = rs2_hit ? alu_rd : rs2_val;
    assign in_ready = !rst;
`else
    logic hazard;
    assign hazard   = dec_legal && (rs1_hit || rs2_hit);
    assign op_a     = rs1_val;
    assign op_b_reg = rs2_val;
    assign in_ready = !rst && !hazard;
`endif

    assign op_b_raw = dec_is_op ? op_b_reg : imm;
    assign op_b     = dec_shift ? {{(XLEN-5){1'b0}}, op_b_raw[4:0]} : op_b_raw;

    logic accept;
    assign accept = in_valid && in_ready;

    always_comb begin
        ex_d      = '0;
        illegal_d = 1'b0;
        if (accept) begin
            if (dec_legal) begin
                ex_d.valid = 1'b1;
                ex_d.rd    = rd_addr;
                ex_d.ra    = op_a;
                ex_d.rb    = op_b;
                ex_d.func3 = func3;
                ex_d.func7 = dec_func7;
            end else begin
                illegal_d = 1'b1;
            end
        end
        wb_d.valid = ex_q.valid && (ex_q.rd != '0);
        wb_d.addr  = ex_q.rd;
        wb_d.data  = alu_rd;
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    logic ex_live;
    assign ex_live   = ex_q.valid && !rst;
    assign alu_ra    = ex_live ? ex_q.ra    : '0;
    assign alu_rb    = ex_live ? ex_q.rb    : '0;
    assign alu_func3 = ex_live ? ex_q.func3 : '0;
    assign alu_func7 = ex_live ? ex_q.func7 : '0;

    assign wb_valid = wb_q.valid && !rst;
    assign wb_addr  = wb_q.addr;
    assign wb_data  = wb_q.data;
    assign illegal  = illegal_q && !rst;

endmodule
